// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor
// Independent safety monitor for the highway/farm intersection controller.
// Samples both lamp outputs, decodes them into a phase and checks for
// conflicting greens, illegal encodings, out-of-order phase changes, short
// yellows and stuck phases. Any violation latches a fault code and drives a
// flash command used by the board to force all-red flashing.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   light_HW     highway lamps {G,Y,R} (100 green, 010 yellow, 001 red)
//   light_FM     farm lamps, same encoding
//   clear_fault  single-cycle pulse, honoured only while faulted
//   phase        decoded phase 00 G/R, 01 Y/R, 10 R/G, 11 R/Y (HW/FM)
//   phase_valid  registered sample is one of the four legal phases
//   fault        latched fault flag
//   fault_code   0 none, 1 CONFLICT, 2 ILLEGAL, 3 SEQ, 4 YEL_SHORT, 5 STUCK
//   flash_en     flash command, 0 outside fault
//   cycle_count  completed R/Y -> G/R re-entries
//
// Optional feature macro: MON_CYCLE_COUNT_EN
//   defined   : cycle_count is a saturating counter of legal R/Y -> G/R
//               changes seen while running (cleared by reset only)
//   undefined : cycle_count is tied to zero
//
// state     | meaning
// ----------+--------------------------------------------------------------
// MON_INIT  | waiting for a valid G/R sample; only CONFLICT/ILLEGAL checked
// MON_RUN   | tracking phase order and durations; all checks active
// MON_FAULT | fault latched, flashing, violations ignored until clear_fault

module traffic_conflict_monitor #(
    parameter int unsigned YEL_MIN    = 3,
    parameter int unsigned WATCHDOG   = 31,
    parameter int unsigned FILTER_CYC = 2,
    parameter int unsigned FLASH_DIV  = 4,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] light_HW,
    input  logic [2:0] light_FM,
    input  logic       clear_fault,
    output logic [1:0] phase,
    output logic       phase_valid,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_en,
    output logic [7:0] cycle_count
);

    localparam logic [2:0] LAMP_G = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b001;

    localparam logic [1:0] PH_GR = 2'b00;
    localparam logic [1:0] PH_YR = 2'b01;
    localparam logic [1:0] PH_RG = 2'b10;
    localparam logic [1:0] PH_RY = 2'b11;

    localparam logic [CNT_W-1:0] DUR_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DUR_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] YEL_MIN_C = CNT_W'(YEL_MIN);
    localparam logic [CNT_W-1:0] WD_C      = CNT_W'(WATCHDOG);
    localparam logic [7:0]       FILT_C    = 8'(FILTER_CYC);
    localparam logic [7:0]       FDIV_LAST = 8'(FLASH_DIV - 1);

    typedef enum logic [1:0] {
        MON_INIT  = 2'd0,
        MON_RUN   = 2'd1,
        MON_FAULT = 2'd2
    } mon_state_t;

    mon_state_t       state;
    logic [2:0]       s_hw;
    logic [2:0]       s_fm;
    logic             s_valid;
    logic [1:0]       s_phase;
    logic [1:0]       phase_hold;
    logic [1:0]       prev;
    logic [1:0]       prev_next;
    logic [CNT_W-1:0] dur;
    logic [7:0]       ill_cnt;
    logic [7:0]       flash_div;

    logic             conflict;
    logic             illegal_hit;
    logic             changed;
    logic             seq_bad;
    logic             yel_short;
    logic             stuck;
    logic [2:0]       viol;

    // Decode of the registered sample; everything downstream works on this.
    always_comb begin
        s_valid = 1'b0;
        s_phase = PH_GR;
        if (s_fm == LAMP_R) begin
            if (s_hw == LAMP_G) begin
                s_valid = 1'b1;
                s_phase = PH_GR;
            end else if (s_hw == LAMP_Y) begin
                s_valid = 1'b1;
                s_phase = PH_YR;
            end
        end else if (s_hw == LAMP_R) begin
            if (s_fm == LAMP_G) begin
                s_valid = 1'b1;
                s_phase = PH_RG;
            end else if (s_fm == LAMP_Y) begin
                s_valid = 1'b1;
                s_phase = PH_RY;
            end
        end
    end

    assign phase_valid = s_valid;
    assign phase       = s_valid ? s_phase : phase_hold;

    // Phase codes were chosen so the legal successor is always prev + 1.
    assign prev_next   = prev + 2'd1;
    assign conflict    = (|s_hw[2:1]) && (|s_fm[2:1]);
    assign illegal_hit = !s_valid && ((ill_cnt + 8'd1) >= FILT_C);
    assign changed     = s_valid && (s_phase != prev);
    assign seq_bad     = changed && (s_phase != prev_next);
    // prev[0] is set exactly for the two yellow phases (Y/R, R/Y).
    assign yel_short   = changed && prev[0] && (dur < YEL_MIN_C);
    assign stuck       = (prev != PH_GR) && (dur > WD_C);

    // Lowest code wins when several violations coincide.
    always_comb begin
        viol = 3'd0;
        if (state != MON_FAULT) begin
            if (conflict) begin
                viol = 3'd1;
            end else if (illegal_hit) begin
                viol = 3'd2;
            end else if (state == MON_RUN) begin
                if (seq_bad) begin
                    viol = 3'd3;
                end else if (yel_short) begin
                    viol = 3'd4;
                end else if (stuck) begin
                    viol = 3'd5;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= MON_INIT;
            s_hw       <= 3'd0;
            s_fm       <= 3'd0;
            phase_hold <= PH_GR;
            prev       <= PH_GR;
            dur        <= '0;
            ill_cnt    <= 8'd0;
            flash_div  <= 8'd0;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            flash_en   <= 1'b0;
        end else begin
            s_hw <= light_HW;
            s_fm <= light_FM;

            if (s_valid) begin
                phase_hold <= s_phase;
            end

            if (s_valid) begin
                ill_cnt <= 8'd0;
            end else if (ill_cnt < FILT_C) begin
                ill_cnt <= ill_cnt + 8'd1;
            end

            if (viol != 3'd0) begin
                state      <= MON_FAULT;
                fault      <= 1'b1;
                fault_code <= viol;
                flash_en   <= 1'b1;
                flash_div  <= 8'd0;
            end else begin
                case (state)
                    MON_INIT: begin
                        if (s_valid && (s_phase == PH_GR)) begin
                            state <= MON_RUN;
                            prev  <= PH_GR;
                            dur   <= DUR_ONE;
                        end
                    end
                    MON_RUN: begin
                        if (changed) begin
                            prev <= s_phase;
                            dur  <= DUR_ONE;
                        end else if (s_valid && (dur != DUR_MAX)) begin
                            dur <= dur + 1'b1;
                        end
                    end
                    MON_FAULT: begin
                        if (clear_fault) begin
                            state      <= MON_INIT;
                            fault      <= 1'b0;
                            fault_code <= 3'd0;
                            flash_en   <= 1'b0;
                            flash_div  <= 8'd0;
                            prev       <= PH_GR;
                            dur        <= '0;
                        end else if (flash_div == FDIV_LAST) begin
                            flash_div <= 8'd0;
                            flash_en  <= ~flash_en;
                        end else begin
                            flash_div <= flash_div + 8'd1;
                        end
                    end
                    default: begin
                        state <= MON_INIT;
                    end
                endcase
            end
        end
    end

`ifdef MON_CYCLE_COUNT_EN
    logic [7:0] cyc_cnt;
    logic       cyc_inc;

    assign cyc_inc = (state == MON_RUN) && (viol == 3'd0) && changed &&
                     (prev == PH_RY) && (s_phase == PH_GR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt <= 8'd0;
        end else if (cyc_inc && (cyc_cnt != 8'hFF)) begin
            cyc_cnt <= cyc_cnt + 8'd1;
        end
    end

    assign cycle_count = cyc_cnt;
`else
    assign cycle_count = 8'd0;
`endif

endmodule

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
Independent safety monitor that reads the highway and farm light outputs of the intersection controller. It decodes the light pair into a phase and checks for conflicting greens, illegal encodings, out-of-order phase changes, short yellows and stuck phases. On any violation it latches a fault code and drives a flash command that the board uses to force all-red flashing. It sits beside the controller, in the same clock domain, with no feedback into the controller.

Parameters:
YEL_MIN, 3, minimum cycles a yellow phase (Y/R or R/Y) must be held before leaving it.
WATCHDOG, 31, maximum cycles any phase other than G/R may be held; must be < 2^CNT_W-1.
FILTER_CYC, 2, consecutive illegal samples required before an ILLEGAL fault.
FLASH_DIV, 4, flash toggles every FLASH_DIV cycles while in fault.
CNT_W, 6, width of the phase-duration counter (saturating).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
light_HW  input  3  highway lamps {G,Y,R}; 100=green, 010=yellow, 001=red.
light_FM  input  3  farm lamps, same encoding.
clear_fault  input  1  single-cycle pulse; honoured only in MON_FAULT.
phase  output  2  decoded phase: 00 G/R, 01 Y/R, 10 R/G, 11 R/Y (HW/FM).
phase_valid  output  1  registered sample decodes to one of the 4 legal phases.
fault  output  1  latched fault flag.
fault_code  output  3  0 none, 1 CONFLICT, 2 ILLEGAL, 3 SEQ, 4 YEL_SHORT, 5 STUCK.
flash_en  output  1  flash command; 0 outside fault.
cycle_count  output  8  completed G/R re-entries (see Optional Feature).

Behaviour:
- Reset: all outputs 0, state MON_INIT, sample regs = 0, counters = 0.
- Input stage: light_HW/light_FM registered every edge (S). Checks are combinational on S. fault/fault_code are registered on the next edge, so latency is 2 rising edges from input change to fault=1.
- Decode: any S pair other than the 4 legal pairs gives phase_valid=0; phase holds its last legal value.
- CONFLICT: both S lamps have the G or Y bit set (G/G, G/Y, Y/G, Y/Y). Unfiltered. Checked in MON_INIT and MON_RUN.
- ILLEGAL: illegal-sample counter increments while phase_valid=0 and clears on any valid sample. Fault when the counter reaches FILTER_CYC. Checked in MON_INIT and MON_RUN.
- States:
  - MON_INIT: waits for a valid G/R sample, then enters MON_RUN with dur=1 and prev=G/R. SEQ, YEL_SHORT and STUCK are not checked here.
  - MON_RUN: all checks active.
  - MON_FAULT: fault=1, fault_code frozen, and the block ignores further violations.
- Duration counter dur: +1 per cycle while the valid phase is unchanged. Saturates at 2^CNT_W-1. Set to 1 on each legal phase change. An invalid sample does not count as a change and does not advance dur.
- SEQ: the only legal order is G/R -> Y/R -> R/G -> R/Y -> G/R. Any other valid-to-valid change is a SEQ fault.
- YEL_SHORT: on leaving Y/R or R/Y with dur < YEL_MIN. Exactly YEL_MIN is legal.
- STUCK: phase != G/R and dur > WATCHDOG. G/R may persist indefinitely.
- Simultaneous violations: the lowest fault_code wins.
- Fault entry: on the entry edge flash_en=1 and the flash divider is cleared. flash_en then toggles every FLASH_DIV cycles.
- Clear: clear_fault in MON_FAULT gives, on the next edge, state MON_INIT, fault=0, fault_code=0, flash_en=0. clear_fault in other states has no effect. If a violation is present on the clear edge, clear still wins; INIT re-detects CONFLICT/ILLEGAL on the following cycle.
- Reset mid-operation returns immediately to the reset values.

Optional Feature:
Macro MON_CYCLE_COUNT_EN.
- Defined: cycle_count increments (saturating at 255) on each legal R/Y -> G/R change in MON_RUN. It is cleared by reset only, not by clear_fault.
- Undefined: cycle_count is tied to 8'd0 and no counter is built.

Test Plan:
- Reset released, lights G/R for 20 cycles -> phase=00, phase_valid=1, fault=0, state reaches MON_RUN after 2 edges.
- Full legal cycle G/R(5) -> Y/R(6) -> R/G(11) -> R/Y(4) -> G/R, repeated twice -> fault=0. With MON_CYCLE_COUNT_EN, cycle_count=2.
- Y/R held 2 cycles then R/G -> fault=1 and fault_code=4 two edges after R/G is applied. flash_en=1, then 0 after 4 cycles, then 1 after 8.
- light_HW=100 and light_FM=100 for 1 cycle in MON_RUN -> fault_code=1. A 1-cycle illegal pair 000/001 -> no fault. A 2-cycle illegal pair -> fault_code=2.
- G/R -> R/G directly -> fault_code=3. R/G held 40 cycles -> fault_code=5 at dur=32.
- In fault, pulse clear_fault -> next edge fault=0, fault_code=0. Lights at R/G stay unchecked until G/R is seen. A clear pulse outside fault -> no change.
